// File: rtl/alarm_sequencer.sv
// alarm_sequencer: IDLE/ARMED/RINGING/SNOOZE controller that decides when the song player sounds.
// Define ALARM_SNOOZE_EN to build in the snooze button, the SNOOZE state and the snooze counter.
module alarm_sequencer #(
    parameter int unsigned RING_TIMEOUT_SEC = 30,
    parameter int unsigned SNOOZE_SEC       = 60,
    parameter int unsigned MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic [3:0] seconds_ones,
    input  logic [2:0] seconds_tens,
    input  logic [3:0] minutes_ones,
    input  logic [2:0] minutes_tens,
    input  logic [3:0] alarm_minutes_ones,
    input  logic [2:0] alarm_minutes_tens,
    input  logic       load_SW,
    input  logic       alarm_off_SW,
    input  logic       snooze_BTN,
    output logic       play_sound,
    output logic       snooze_led,
    output logic [1:0] state,
    output logic [2:0] snooze_count,
    output logic [7:0] sec_left
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_e;

    localparam logic [7:0] RING_LOAD = 8'(RING_TIMEOUT_SEC);

    state_e     state_q, state_d;
    logic [7:0] sec_left_q, sec_left_d;
    logic [2:0] snooze_cnt_q, snooze_cnt_d;
    logic       match, match_q, trigger, override;

    assign match = (minutes_ones == alarm_minutes_ones) && (minutes_tens == alarm_minutes_tens)
                && (seconds_ones == 4'd0) && (seconds_tens == 3'd0);
    // Only the rising edge of match fires, so a held match or arming during a match stays silent.
    assign trigger  = match & ~match_q;
    assign override = load_SW | alarm_off_SW;

`ifdef ALARM_SNOOZE_EN
    localparam logic [7:0] SNOOZE_LOAD = 8'(SNOOZE_SEC);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);
    logic snooze_ok;
    assign snooze_ok = snooze_BTN && (snooze_cnt_q < SNOOZE_MAX);
`else
    logic unused_snooze;
    assign unused_snooze = ^{snooze_BTN, 8'(SNOOZE_SEC), 3'(MAX_SNOOZE)};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sec_left_q   <= 8'd0;
            snooze_cnt_q <= 3'd0;
            match_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sec_left_q   <= sec_left_d;
            snooze_cnt_q <= snooze_cnt_d;
            match_q      <= match;
        end
    end

    always_comb begin
        // NOTE: every next-state signal holds its current value by default, so no path infers a latch.
        state_d      = state_q;
        sec_left_d   = sec_left_q;
        snooze_cnt_d = snooze_cnt_q;
        if (override) begin
            state_d      = ST_IDLE;
            sec_left_d   = 8'd0;
            snooze_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (trigger) begin
                        state_d      = ST_RINGING;
                        sec_left_d   = RING_LOAD;
                        snooze_cnt_d = 3'd0;
                    end
                end
                ST_RINGING: begin
`ifdef ALARM_SNOOZE_EN
                    // Snooze outranks the final tick so a last-second press still snoozes.
                    if (snooze_ok) begin
                        state_d      = ST_SNOOZE;
                        sec_left_d   = SNOOZE_LOAD;
                        snooze_cnt_d = snooze_cnt_q + 3'd1;
                    end else
`endif
                    if (tick_1hz) begin
                        if (sec_left_q == 8'd1) begin
                            state_d      = ST_ARMED;
                            sec_left_d   = 8'd0;
                            snooze_cnt_d = 3'd0;
                        end else begin
                            sec_left_d = sec_left_q - 8'd1;
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (tick_1hz) begin
                        if (sec_left_q == 8'd1) begin
                            state_d    = ST_RINGING;
                            sec_left_d = RING_LOAD;
                        end else begin
                            sec_left_d = sec_left_q - 8'd1;
                        end
                    end
                end
`endif
                default: begin
                    state_d      = ST_IDLE;
                    sec_left_d   = 8'd0;
                    snooze_cnt_d = 3'd0;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign play_sound   = (state_q == ST_RINGING);
    assign sec_left     = sec_left_q;
    assign snooze_count = snooze_cnt_q;
`ifdef ALARM_SNOOZE_EN
    assign snooze_led   = (state_q == ST_SNOOZE);
`else
    assign snooze_led   = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboard bench for alarm_sequencer: expected outputs are queued as stimulus is driven
// and compared on the falling edge after the clock edge that should produce them.
module tb_alarm_sequencer;

    localparam int RING = 30;
    localparam int SNZ  = 60;
    localparam int MAXS = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;
    localparam logic [1:0] ST_SNOOZE  = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [3:0] seconds_ones = 4'd0;
    logic [2:0] seconds_tens = 3'd0;
    logic [3:0] minutes_ones = 4'd0;
    logic [2:0] minutes_tens = 3'd0;
    logic [3:0] alarm_minutes_ones = 4'd5;
    logic [2:0] alarm_minutes_tens = 3'd0;
    logic       load_SW = 1'b0;
    logic       alarm_off_SW = 1'b0;
    logic       snooze_BTN = 1'b0;
    logic       play_sound;
    logic       snooze_led;
    logic [1:0] state;
    logic [2:0] snooze_count;
    logic [7:0] sec_left;

    alarm_sequencer #(
        .RING_TIMEOUT_SEC(RING),
        .SNOOZE_SEC      (SNZ),
        .MAX_SNOOZE      (MAXS)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .tick_1hz          (tick_1hz),
        .seconds_ones      (seconds_ones),
        .seconds_tens      (seconds_tens),
        .minutes_ones      (minutes_ones),
        .minutes_tens      (minutes_tens),
        .alarm_minutes_ones(alarm_minutes_ones),
        .alarm_minutes_tens(alarm_minutes_tens),
        .load_SW           (load_SW),
        .alarm_off_SW      (alarm_off_SW),
        .snooze_BTN        (snooze_BTN),
        .play_sound        (play_sound),
        .snooze_led        (snooze_led),
        .state             (state),
        .snooze_count      (snooze_count),
        .sec_left          (sec_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [2:0] cnt;
        logic [7:0] sec;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [14:0] got, want;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur  = exp_q.pop_front();
            got  = {state, play_sound, snooze_led, snooze_count, sec_left};
            want = {cur.st, cur.st == ST_RINGING, cur.st == ST_SNOOZE, cur.cnt, cur.sec};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got state=%0d play=%0b led=%0b cnt=%0d sec=%0d, expected state=%0d play=%0b led=%0b cnt=%0d sec=%0d",
                         cur.name, state, play_sound, snooze_led, snooze_count, sec_left,
                         cur.st, cur.st == ST_RINGING, cur.st == ST_SNOOZE, cur.cnt, cur.sec);
            end
        end
    end

    // One clock edge of stimulus; inputs change only just after a falling edge.
    task automatic step(input logic tk, input logic snz, input logic [1:0] st,
                        input logic [2:0] cnt, input logic [7:0] sec, input string name);
        tick_1hz   = tk;
        snooze_BTN = snz;
        exp_q.push_back('{name, st, cnt, sec});
        @(posedge clk);
        @(negedge clk);
        #1;
        tick_1hz   = 1'b0;
        snooze_BTN = 1'b0;
    endtask

    task automatic set_time(input logic [2:0] mt, input logic [3:0] mo,
                            input logic [2:0] st, input logic [3:0] so);
        minutes_tens = mt;
        minutes_ones = mo;
        seconds_tens = st;
        seconds_ones = so;
    endtask

    // From ARMED: step the clock 04:59 -> 05:00 on a tick to produce a fresh match edge.
    task automatic retrigger(input string name);
        set_time(3'd0, 4'd4, 3'd5, 4'd9);
        step(1'b1, 1'b0, ST_ARMED, 3'd0, 8'd0, {name, "_pre"});
        set_time(3'd0, 4'd5, 3'd0, 4'd0);
        step(1'b1, 1'b0, ST_RINGING, 3'd0, 8'(RING), name);
    endtask

    task automatic test_reset;
        set_time(3'd0, 4'd0, 3'd0, 4'd0);
        #1;
        checks++;
        if ({state, play_sound, snooze_led, snooze_count, sec_left} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values: got state=%0d play=%0b led=%0b cnt=%0d sec=%0d, expected all zero",
                     state, play_sound, snooze_led, snooze_count, sec_left);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b0, 1'b0, ST_ARMED, 3'd0, 8'd0, "leave_reset_arms");
    endtask

    task automatic test_trigger;
        retrigger("trigger");
    endtask

    task automatic test_timeout;
        for (int i = 1; i < RING; i++)
            step(1'b1, 1'b0, ST_RINGING, 3'd0, 8'(RING - i), "ring_countdown");
        step(1'b1, 1'b0, ST_ARMED, 3'd0, 8'd0, "ring_timeout");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, ST_ARMED, 3'd0, 8'd0, "held_match_no_retrigger");
    endtask

    task automatic test_snooze;
        retrigger("snooze_ring");
        step(1'b1, 1'b0, ST_RINGING, 3'd0, 8'(RING - 1), "snooze_ring_tick");
`ifdef ALARM_SNOOZE_EN
        for (int k = 1; k <= MAXS; k++) begin
            step(1'b0, 1'b1, ST_SNOOZE, 3'(k), 8'(SNZ), "snooze_enter");
            step(1'b0, 1'b1, ST_SNOOZE, 3'(k), 8'(SNZ), "snooze_btn_in_snooze_ignored");
            for (int i = 1; i < SNZ; i++)
                step(1'b1, 1'b0, ST_SNOOZE, 3'(k), 8'(SNZ - i), "snooze_countdown");
            step(1'b1, 1'b0, ST_RINGING, 3'(k), 8'(RING), "snooze_expire_rings");
        end
        step(1'b0, 1'b1, ST_RINGING, 3'(MAXS), 8'(RING), "snooze_limit_ignored");
        step(1'b1, 1'b1, ST_RINGING, 3'(MAXS), 8'(RING - 1), "snooze_limit_tick");
`else
        step(1'b0, 1'b1, ST_RINGING, 3'd0, 8'(RING - 1), "snooze_disabled_ignored");
        step(1'b1, 1'b1, ST_RINGING, 3'd0, 8'(RING - 2), "snooze_disabled_tick");
`endif
    endtask

    task automatic test_override;
        alarm_off_SW = 1'b1;
        step(1'b1, 1'b1, ST_IDLE, 3'd0, 8'd0, "off_from_ringing");
        step(1'b0, 1'b0, ST_IDLE, 3'd0, 8'd0, "off_held_idle");
        alarm_off_SW = 1'b0;
        step(1'b0, 1'b0, ST_ARMED, 3'd0, 8'd0, "off_release_arms");
        for (int pass = 0; pass < 2; pass++) begin
            retrigger("override_ring");
`ifdef ALARM_SNOOZE_EN
            step(1'b0, 1'b1, ST_SNOOZE, 3'd1, 8'(SNZ), "override_setup_snooze");
            step(1'b1, 1'b0, ST_SNOOZE, 3'd1, 8'(SNZ - 1), "override_setup_tick");
`else
            step(1'b1, 1'b0, ST_RINGING, 3'd0, 8'(RING - 1), "override_setup_tick");
`endif
            if (pass == 0) alarm_off_SW = 1'b1;
            else           load_SW = 1'b1;
            step(1'b1, 1'b1, ST_IDLE, 3'd0, 8'd0, pass == 0 ? "override_alarm_off" : "override_load");
            alarm_off_SW = 1'b0;
            load_SW      = 1'b0;
            step(1'b0, 1'b0, ST_ARMED, 3'd0, 8'd0, "override_release_arms");
        end
    endtask

    task automatic test_simultaneous;
        retrigger("simul_ring");
        for (int i = 1; i < RING; i++)
            step(1'b1, 1'b0, ST_RINGING, 3'd0, 8'(RING - i), "simul_countdown");
`ifdef ALARM_SNOOZE_EN
        step(1'b1, 1'b1, ST_SNOOZE, 3'd1, 8'(SNZ), "snooze_beats_final_tick");
        alarm_off_SW = 1'b1;
        step(1'b0, 1'b0, ST_IDLE, 3'd0, 8'd0, "simul_cleanup_off");
        alarm_off_SW = 1'b0;
        step(1'b0, 1'b0, ST_ARMED, 3'd0, 8'd0, "simul_cleanup_arm");
`else
        step(1'b1, 1'b1, ST_ARMED, 3'd0, 8'd0, "final_tick_with_btn_times_out");
`endif
    endtask

    task automatic test_reset_mid_ring;
        retrigger("midring");
        step(1'b1, 1'b0, ST_RINGING, 3'd0, 8'(RING - 1), "midring_tick");
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({state, play_sound, snooze_led, snooze_count, sec_left} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_ring_async: got state=%0d play=%0b led=%0b cnt=%0d sec=%0d, expected all zero before clk",
                     state, play_sound, snooze_led, snooze_count, sec_left);
        end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b0, 1'b0, ST_ARMED, 3'd0, 8'd0, "reset_release_arms");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, ST_ARMED, 3'd0, 8'd0, "reset_release_no_ring");
        retrigger("ring_after_new_edge");
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_timeout();
        test_snooze();
        test_override();
        test_simultaneous();
        test_reset_mid_ring();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Sequencing controller for the alarm path. It compares the running mm:ss counter against the stored alarm minute and decides when the song player sounds. It runs an IDLE/ARMED/RINGING/SNOOZE state machine with a ring timeout and a bounded snooze count. It sits between the minute/second counters and set-alarm registers on one side and the song player's `play_sound` input on the other.

## Interface
Parameters:
- `RING_TIMEOUT_SEC`, default 30: number of 1 Hz ticks a ring lasts before it stops automatically; legal range 1–255.
- `SNOOZE_SEC`, default 60: number of 1 Hz ticks spent silent in SNOOZE; legal range 1–255.
- `MAX_SNOOZE`, default 3: number of snoozes allowed per alarm event; legal range 0–7.

Ports:
- `clk` in 1: system clock. The block uses this single clock only.
- `reset_n` in 1: asynchronous, active-low reset.
- `tick_1hz` in 1: one-`clk`-wide strobe, synchronous to `clk`, one pulse per counted second (fast-forward rate also allowed).
- `seconds_ones` in 4, `seconds_tens` in 3: current seconds, BCD.
- `minutes_ones` in 4, `minutes_tens` in 3: current minutes, BCD.
- `alarm_minutes_ones` in 4, `alarm_minutes_tens` in 3: alarm minute set by the set-alarm block, BCD.
- `load_SW` in 1: alarm-setting mode; level-sensitive; forces IDLE while high.
- `alarm_off_SW` in 1: alarm disable; level-sensitive; forces IDLE while high.
- `snooze_BTN` in 1: one-`clk` pulse, already debounced upstream.
- `play_sound` out 1: high while in RINGING; drives the song player.
- `snooze_led` out 1: high while in SNOOZE.
- `state` out 2: 0 = IDLE, 1 = ARMED, 2 = RINGING, 3 = SNOOZE.
- `snooze_count` out 3: number of snoozes used in the current alarm event.
- `sec_left` out 8: remaining ticks in RINGING or SNOOZE; 0 in other states.

## Operation
- **Match condition.** `match` = current minutes equal alarm minutes (both BCD digits) AND `seconds_ones`==0 AND `seconds_tens`==0.
- **Trigger.** `match_q` registers `match` every cycle, in all states. `trigger` = `match & ~match_q` (rising edge only).
  - Consequence: enabling the alarm while `match` is already high does not fire.
  - Consequence: a held `match` never retriggers.
- **Override.** `load_SW | alarm_off_SW` high → next state IDLE from any state. This has the highest priority. On the same edge, `snooze_count` and `sec_left` are cleared.
- **IDLE** → ARMED when `load_SW` and `alarm_off_SW` are both low.
- **ARMED** → RINGING on `trigger`. On entry, load `sec_left` = `RING_TIMEOUT_SEC` and set `snooze_count` = 0.
- **RINGING**, priorities in order:
  1. `snooze_BTN` with `snooze_count` < `MAX_SNOOZE` → SNOOZE. Load `sec_left` = `SNOOZE_SEC`; increment `snooze_count`.
  2. Otherwise, `tick_1hz` with `sec_left`==1 → ARMED. Clear `sec_left`; clear `snooze_count`.
  3. Otherwise, `tick_1hz` → decrement `sec_left`.
  - `snooze_BTN` with `snooze_count`==`MAX_SNOOZE` is ignored.
  - `trigger` is ignored.
- **SNOOZE**:
  - `tick_1hz` with `sec_left`==1 → RINGING. Reload `sec_left` = `RING_TIMEOUT_SEC`.
  - Otherwise, `tick_1hz` → decrement `sec_left`.
  - `snooze_BTN` and `trigger` are ignored.
- **Ring length.** RINGING lasts exactly `RING_TIMEOUT_SEC` ticks. The first tick after entry counts.
- **Arithmetic.** `sec_left` is an 8-bit unsigned counter. It never wraps, because it leaves the state when it reaches 1. `snooze_count` saturates at `MAX_SNOOZE`.

## Timing
- **Reset.** On `reset_n` low, all outputs go to 0 asynchronously: `state`=IDLE, `play_sound`=0, `snooze_led`=0, `snooze_count`=0, `sec_left`=0, `match_q`=0.
- **Leaving reset.** After release, the first edge with both switches low moves the block to ARMED. If `match` is already high on that first edge, `match_q` captures it and no trigger occurs.
- **Output registering.** `play_sound` and `snooze_led` are decoded from the registered state, so there is no combinational path from inputs.
- **Latency.** Trigger seen at edge N → `play_sound` high after edge N. The same one-edge latency applies to snooze, timeout and override.
- **Reset mid-ring.** `play_sound` drops immediately, without waiting for `clk`.
- **Simultaneous events.**
  - Snooze + final tick in RINGING: snooze wins.
  - Override + any other event: override wins.

## Configuration
- **`ALARM_SNOOZE_EN` defined:** full behaviour as above.
- **`ALARM_SNOOZE_EN` undefined:**
  - `snooze_BTN` is ignored and SNOOZE is unreachable.
  - `snooze_led` and `snooze_count` are tied to 0.
  - RINGING exits only by timeout or override.
  - `MAX_SNOOZE` and `SNOOZE_SEC` are unused.

## Test plan
1. **Trigger.** Alarm 05, `alarm_off_SW`=0. Clock steps 04:59 → 05:00 on a tick → `state`=2, `play_sound`=1, `sec_left`=30, one cycle later.
2. **Timeout.** Continue test 1 with 30 ticks → after the 30th tick `play_sound`=0 and `state`=1. Clock still at 05:xx → no retrigger.
3. **Snooze.**
   - `snooze_BTN` while RINGING → `state`=3, `snooze_count`=1, `sec_left`=60.
   - After 60 ticks → `state`=2, `sec_left`=30.
   - Repeat to `snooze_count`=3; a 4th snooze pulse is ignored and the block stays RINGING.
4. **Override.** `alarm_off_SW`=1 during SNOOZE → `state`=0, `snooze_count`=0, `sec_left`=0 next cycle. Repeat with `load_SW`=1 → same result.
5. **Simultaneous events.** `snooze_BTN` and `tick_1hz` in the same cycle, RINGING with `sec_left`=1 → `state`=3, `snooze_count` incremented.
6. **Reset mid-ring.** Pull `reset_n` low mid-RINGING → `play_sound`=0 before the next `clk` edge. Release with the clock at 05:00 → block goes to ARMED and does not ring until the next rising edge of `match`.
